// File: rtl/smul_arbiter.sv
// Round-robin front end that shares one X25519 ladder core among NREQ requesters.
// Latches operands, sequences the core's rst-as-start protocol and returns x_q or a timeout error.
module smul_arbiter #(
    parameter int          NREQ        = 4,
    parameter int          WIDTH       = 255,
    parameter int          LOAD_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 32'd2000000,
    localparam int         IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_k,
    input  logic [NREQ*WIDTH-1:0] req_x,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]      resp_xq,
    output logic                  resp_err,
    output logic                  core_rst,
    output logic [WIDTH-1:0]      core_k,
    output logic [WIDTH-1:0]      core_x,
    input  logic [WIDTH-1:0]      core_xq,
    input  logic                  core_done,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [31:0]    load_cnt;
    logic [31:0]    tmo_cnt;
    logic           found;
    logic [IDW-1:0] sel;
    int             idx;

    // First valid requester at or after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int j = 0; j < NREQ; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && found) req_ready[sel] = 1'b1;
    end

    always_comb begin
        resp_valid = '0;
        if (state == S_RESP) resp_valid[grant_id] = 1'b1;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            core_rst <= 1'b1;
            core_k   <= '0;
            core_x   <= '0;
            resp_xq  <= '0;
            resp_err <= 1'b0;
            load_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    core_rst <= 1'b1;
                    if (found) begin
                        core_k   <= req_k[int'(sel)*WIDTH +: WIDTH];
                        core_x   <= req_x[int'(sel)*WIDTH +: WIDTH];
                        grant_id <= sel;
                        rr_ptr   <= (int'(sel) == NREQ-1) ? '0 : sel + 1'b1;
                        load_cnt <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_cnt == LOAD_CYCLES-1) begin
                        core_rst <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= S_RUN;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // done takes priority over a coincident timeout
                    if (core_done) begin
                        resp_xq  <= core_xq;
                        resp_err <= 1'b0;
                        core_rst <= 1'b1;
                        state    <= S_RESP;
                    end else if (tmo_cnt == TIMEOUT-1) begin
                        resp_xq  <= '0;
                        resp_err <= 1'b1;
                        core_rst <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready[grant_id]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
